// File: rtl/mips_ctrl_pkg.sv
// mips_ctrl_pkg: shared encodings for the multi-cycle MIPS control unit
package mips_ctrl_pkg;
  typedef enum logic [3:0] {
    FETCH     = 4'd0,
    DECODE    = 4'd1,
    MEM_ADR   = 4'd2,
    MEM_READ  = 4'd3,
    MEM_WB    = 4'd4,
    MEM_WRITE = 4'd5,
    EXECUTE   = 4'd6,
    ALU_WB    = 4'd7,
    BRANCH    = 4'd8,
    JUMP      = 4'd9,
    ADDI_EXEC = 4'd10,
    ADDI_WB   = 4'd11
  } state_t;
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [1:0] ULA_ADD   = 2'b00;
  localparam logic [1:0] ULA_SUB   = 2'b01;
  localparam logic [1:0] ULA_FUNCT = 2'b10;
  localparam logic [1:0] SRCB_REG     = 2'b00;
  localparam logic [1:0] SRCB_FOUR    = 2'b01;
  localparam logic [1:0] SRCB_IMM     = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;
  localparam logic [1:0] PCSRC_ULA    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;
  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] ula_op;
    logic [1:0] pc_source;
  } ctrl_t;
  function automatic logic is_legal(input logic [5:0] op);
    return op == OP_RTYPE || op == OP_LW || op == OP_SW || op == OP_BEQ || op == OP_J || op == OP_ADDI;
  endfunction
endpackage

// File: rtl/mips_ctrl_decode.sv
// mips_ctrl_decode: maps the control state (and mem_ready in FETCH) to the datapath control word
module mips_ctrl_decode
  import mips_ctrl_pkg::*;
(
  input  state_t st,
  input  logic   mem_ready,
  output ctrl_t  cw
);
  // Moore word per state; FETCH loads IR and PC only once memory has answered
  always_comb begin
    cw = '0;
    case (st)
      FETCH: begin
        cw.mem_read  = 1'b1;
        cw.alu_src_b = SRCB_FOUR;
        cw.ula_op    = ULA_ADD;
        cw.pc_source = PCSRC_ULA;
        cw.ir_write  = mem_ready;
        cw.pc_write  = mem_ready;
      end
      DECODE:    cw.alu_src_b = SRCB_IMM_SH2;
      MEM_ADR: begin
        cw.alu_src_a = 1'b1;
        cw.alu_src_b = SRCB_IMM;
      end
      MEM_READ: begin
        cw.mem_read = 1'b1;
        cw.iord     = 1'b1;
      end
      MEM_WB: begin
        cw.reg_write  = 1'b1;
        cw.mem_to_reg = 1'b1;
      end
      MEM_WRITE: begin
        cw.mem_write = 1'b1;
        cw.iord      = 1'b1;
      end
      EXECUTE: begin
        cw.alu_src_a = 1'b1;
        cw.alu_src_b = SRCB_REG;
        cw.ula_op    = ULA_FUNCT;
      end
      ALU_WB: begin
        cw.reg_write = 1'b1;
        cw.reg_dst   = 1'b1;
      end
      BRANCH: begin
        cw.alu_src_a     = 1'b1;
        cw.ula_op        = ULA_SUB;
        cw.pc_write_cond = 1'b1;
        cw.pc_source     = PCSRC_ALUOUT;
      end
      JUMP: begin
        cw.pc_write  = 1'b1;
        cw.pc_source = PCSRC_JUMP;
      end
      ADDI_EXEC: begin
        cw.alu_src_a = 1'b1;
        cw.alu_src_b = SRCB_IMM;
      end
      ADDI_WB:   cw.reg_write = 1'b1;
      default: begin
        cw.mem_read  = 1'b1;
        cw.alu_src_b = SRCB_FOUR;
      end
    endcase
  end
endmodule

// File: rtl/mips_multicycle_control.sv
// mips_multicycle_control: multi-cycle MIPS sequencer with retire counter and sticky illegal-opcode flag
module mips_multicycle_control
  import mips_ctrl_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [5:0]       opcode,
  input  logic             mem_ready,
  output logic             PCWrite,
  output logic             PCWriteCond,
  output logic             IorD,
  output logic             MemRead,
  output logic             MemWrite,
  output logic             IRWrite,
  output logic             MemtoReg,
  output logic             RegDst,
  output logic             RegWrite,
  output logic             ALUSrcA,
  output logic [1:0]       ALUSrcB,
  output logic [1:0]       ula_operation,
  output logic [1:0]       PCSource,
  output logic [3:0]       state,
  output logic             illegal_op,
  output logic [CNT_W-1:0] instr_count
);
  state_t cur, nxt;
  ctrl_t  cw;
  logic   retire, bad_op;
  mips_ctrl_decode u_decode (.st(cur), .mem_ready(mem_ready), .cw(cw));
  // Next state: memory states wait on mem_ready, DECODE/MEM_ADR dispatch on opcode
  always_comb begin
    nxt = FETCH;
    case (cur)
      FETCH:     nxt = mem_ready ? DECODE : FETCH;
      DECODE:    nxt = (opcode == OP_LW || opcode == OP_SW) ? MEM_ADR :
                       opcode == OP_RTYPE ? EXECUTE :
                       opcode == OP_BEQ   ? BRANCH :
                       opcode == OP_J     ? JUMP :
                       opcode == OP_ADDI  ? ADDI_EXEC : FETCH;
      MEM_ADR:   nxt = opcode == OP_SW ? MEM_WRITE : MEM_READ;
      MEM_READ:  nxt = mem_ready ? MEM_WB : MEM_READ;
      MEM_WRITE: nxt = mem_ready ? FETCH : MEM_WRITE;
      EXECUTE:   nxt = ALU_WB;
      ADDI_EXEC: nxt = ADDI_WB;
      default:   nxt = FETCH;
    endcase
  end
  assign retire = nxt == FETCH && (cur == MEM_WB || cur == MEM_WRITE || cur == ALU_WB ||
                                   cur == BRANCH || cur == JUMP || cur == ADDI_WB);
  assign bad_op = cur == DECODE && !is_legal(opcode);
  // State register, retired-instruction counter and sticky illegal flag
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cur         <= FETCH;
      instr_count <= '0;
      illegal_op  <= 1'b0;
    end else begin
      cur         <= nxt;
      instr_count <= instr_count + CNT_W'(retire);
      illegal_op  <= illegal_op | bad_op;
    end
  end
  assign state         = cur;
  assign PCWrite       = cw.pc_write & reset;
  assign PCWriteCond   = cw.pc_write_cond & reset;
  assign IorD          = cw.iord;
  assign MemRead       = cw.mem_read & reset;
  assign MemWrite      = cw.mem_write & reset;
  assign IRWrite       = cw.ir_write & reset;
  assign MemtoReg      = cw.mem_to_reg;
  assign RegDst        = cw.reg_dst;
  assign RegWrite      = cw.reg_write & reset;
  assign ALUSrcA       = cw.alu_src_a;
  assign ALUSrcB       = cw.alu_src_b;
  assign ula_operation = cw.ula_op;
  assign PCSource      = cw.pc_source;
endmodule

// File: tb/tb_mips_multicycle_control.sv
// tb_mips_multicycle_control: table, directed and random checks against a path-based reference model
module tb_mips_multicycle_control;
  typedef struct packed {
    logic       pcw;
    logic       pcwc;
    logic       iord;
    logic       mrd;
    logic       mwr;
    logic       irw;
    logic       m2r;
    logic       rdst;
    logic       rwr;
    logic       sa;
    logic [1:0] sb;
    logic [1:0] op;
    logic [1:0] ps;
  } tb_cw_t;
  typedef struct {
    logic [5:0] op;
    int         cycles;
    int         retire;
    logic       ill;
  } vec_t;
  typedef int q_t[$];
  logic clock, reset, mem_ready;
  logic [5:0] opcode;
  logic PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg, RegDst, RegWrite, ALUSrcA;
  logic [1:0] ALUSrcB, ula_operation, PCSource;
  logic [3:0] state;
  logic illegal_op;
  logic [31:0] instr_count;
  tb_cw_t dut_cw, exp_tab[12];
  vec_t vecs[7];
  int tests = 0, fails = 0;
  int m_st = 0;
  logic [31:0] m_cnt = 0;
  logic m_ill = 0;
  int g_cyc = 0, g_mw = 0, g_rw = 0;
  mips_multicycle_control #(.CNT_W(32)) dut (
    .clock(clock), .reset(reset), .opcode(opcode), .mem_ready(mem_ready),
    .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD), .MemRead(MemRead),
    .MemWrite(MemWrite), .IRWrite(IRWrite), .MemtoReg(MemtoReg), .RegDst(RegDst),
    .RegWrite(RegWrite), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ula_operation(ula_operation),
    .PCSource(PCSource), .state(state), .illegal_op(illegal_op), .instr_count(instr_count)
  );
  assign dut_cw = {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg, RegDst,
                   RegWrite, ALUSrcA, ALUSrcB, ula_operation, PCSource};
  initial clock = 1'b0;
  always #5 clock = ~clock;
  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endfunction
  function automatic tb_cw_t mk(input bit pcw, pcwc, iord, mrd, mwr, irw, m2r, rdst, rwr, sa,
                                input bit [1:0] sb, op, ps);
    return {pcw, pcwc, iord, mrd, mwr, irw, m2r, rdst, rwr, sa, sb, op, ps};
  endfunction
  function automatic q_t path_of(input logic [5:0] op);
    case (op)
      6'b100011: return '{0, 1, 2, 3, 4};
      6'b101011: return '{0, 1, 2, 5};
      6'b000000: return '{0, 1, 6, 7};
      6'b000100: return '{0, 1, 8};
      6'b000010: return '{0, 1, 9};
      6'b001000: return '{0, 1, 10, 11};
      default:   return '{0, 1};
    endcase
  endfunction
  // no write enable may be seen while reset is held low
  always @(negedge clock)
    if (!reset) chk("we_in_reset", {PCWrite, PCWriteCond, IRWrite, MemRead, MemWrite, RegWrite}, 0);
  task automatic cycle(input logic [5:0] op, input logic mr);
    tb_cw_t e;
    q_t p;
    int idx, nx;
    opcode = op;
    mem_ready = mr;
    #1;
    e = exp_tab[m_st];
    if (m_st == 0) begin
      e.pcw = mr;
      e.irw = mr;
    end
    chk("state", state, m_st);
    chk("ctrl", dut_cw, e);
    chk("count", instr_count, m_cnt);
    chk("illegal", illegal_op, m_ill);
    g_cyc++;
    g_mw += MemWrite;
    g_rw += RegWrite;
    p = path_of(op);
    nx = m_st;
    if (!((m_st == 0 || m_st == 3 || m_st == 5) && !mr)) begin
      idx = p.size() - 1;
      for (int i = 0; i < p.size(); i++) if (p[i] == m_st) idx = i;
      if (idx == p.size() - 1) begin
        nx = 0;
        if (p.size() > 2) m_cnt++;
        else m_ill = 1'b1;
      end else nx = p[idx+1];
    end
    @(posedge clock);
    #1;
    m_st = nx;
  endtask
  initial begin
    logic [5:0] cur_op;
    logic [31:0] c0;
    int n, c_start, mw_start, rw_start;
    logic [5:0] ops[6];
    ops = '{6'b100011, 6'b101011, 6'b000000, 6'b000100, 6'b000010, 6'b001000};
    exp_tab[0]  = mk(0,0,0,1,0,0,0,0,0,0, 2'b01, 2'b00, 2'b00);
    exp_tab[1]  = mk(0,0,0,0,0,0,0,0,0,0, 2'b11, 2'b00, 2'b00);
    exp_tab[2]  = mk(0,0,0,0,0,0,0,0,0,1, 2'b10, 2'b00, 2'b00);
    exp_tab[3]  = mk(0,0,1,1,0,0,0,0,0,0, 2'b00, 2'b00, 2'b00);
    exp_tab[4]  = mk(0,0,0,0,0,0,1,0,1,0, 2'b00, 2'b00, 2'b00);
    exp_tab[5]  = mk(0,0,1,0,1,0,0,0,0,0, 2'b00, 2'b00, 2'b00);
    exp_tab[6]  = mk(0,0,0,0,0,0,0,0,0,1, 2'b00, 2'b10, 2'b00);
    exp_tab[7]  = mk(0,0,0,0,0,0,0,1,1,0, 2'b00, 2'b00, 2'b00);
    exp_tab[8]  = mk(0,1,0,0,0,0,0,0,0,1, 2'b00, 2'b01, 2'b01);
    exp_tab[9]  = mk(1,0,0,0,0,0,0,0,0,0, 2'b00, 2'b00, 2'b10);
    exp_tab[10] = mk(0,0,0,0,0,0,0,0,0,1, 2'b10, 2'b00, 2'b00);
    exp_tab[11] = mk(0,0,0,0,0,0,0,0,1,0, 2'b00, 2'b00, 2'b00);
    vecs = '{'{6'b100011, 5, 1, 1'b0}, '{6'b101011, 4, 1, 1'b0}, '{6'b000000, 4, 1, 1'b0},
             '{6'b001000, 4, 1, 1'b0}, '{6'b000100, 3, 1, 1'b0}, '{6'b000010, 3, 1, 1'b0},
             '{6'b111111, 2, 0, 1'b1}};
    reset = 1'b1;
    mem_ready = 1'b1;
    opcode = 6'b0;
    #1 reset = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    chk("rst_state", state, 0);
    chk("rst_we", {PCWrite, IRWrite, MemRead, MemWrite, RegWrite}, 0);
    chk("rst_count", instr_count, 0);
    chk("rst_illegal", illegal_op, 0);
    reset = 1'b1;
    #1;
    chk("first_fetch", {MemRead, IRWrite, PCWrite}, 3'b111);
    foreach (vecs[k]) begin
      c0 = m_cnt;
      cycle(vecs[k].op, 1'b1);
      n = 1;
      while (state != 4'd0 && n < 20) begin
        cycle(vecs[k].op, 1'b1);
        n++;
      end
      chk($sformatf("vec%0d_cycles", k), n, vecs[k].cycles);
      chk($sformatf("vec%0d_count", k), instr_count, c0 + 32'(vecs[k].retire));
      chk($sformatf("vec%0d_illegal", k), illegal_op, vecs[k].ill);
    end
    c_start = g_cyc;
    mw_start = g_mw;
    rw_start = g_rw;
    repeat (3) cycle(6'b101011, 1'b1);
    cycle(6'b101011, 1'b0);
    cycle(6'b101011, 1'b0);
    cycle(6'b101011, 1'b1);
    chk("sw_cycles", g_cyc - c_start, 6);
    chk("sw_memwrite", g_mw - mw_start, 3);
    chk("sw_regwrite", g_rw - rw_start, 0);
    chk("sw_back_fetch", state, 0);
    rw_start = g_rw;
    repeat (3) cycle(6'b100011, 1'b1);
    cycle(6'b100011, 1'b0);
    reset = 1'b0;
    #1;
    chk("midrst_state", state, 0);
    chk("midrst_count", instr_count, 0);
    chk("midrst_illegal", illegal_op, 0);
    chk("midrst_regwrite", RegWrite, 0);
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b1;
    m_st = 0;
    m_cnt = 0;
    m_ill = 1'b0;
    cycle(6'b000000, 1'b1);
    chk("midrst_no_rw", g_rw - rw_start, 0);
    repeat (2) cycle(6'b111111, 1'b1);
    chk("ill_set", illegal_op, 1);
    c0 = m_cnt;
    repeat (4) cycle(6'b000000, 1'b1);
    chk("ill_sticky", illegal_op, 1);
    chk("ill_rtype_count", instr_count, c0 + 32'd1);
    cur_op = 6'b0;
    for (int i = 0; i < 1500; i++) begin
      if (m_st == 0) cur_op = $urandom_range(0, 7) == 0 ? 6'($urandom) : ops[$urandom_range(0, 5)];
      cycle(cur_op, $urandom_range(0, 3) != 0);
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
